sha256_round_sched: RTL and testbench

Sequencer for the SHA-256 compression round unit (xunitF). It accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready stream and keeps the running hash state H0..H7. For each block it starts the round unit and supplies W[t] and K[t] for all 64 rounds, expanding the message schedule on the fly. It then adds the round unit's result into H and presents the updated digest. It sits between the host/DMA word stream and one round-unit instance.

---
 rtl/sha256_round_sched.sv | 167 ++++++++++++++++
 tb/tb_sha256_round_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_sched.sv
// SHA-256 block sequencer: loads 16 message words, feeds W[t]/K[t] to an external
// round unit for 64 rounds, then folds the round unit's result into the hash state.
module sha256_round_sched #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hash_init,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  busy,
    output logic                  digest_valid,
    output logic [8*DATA_W-1:0]   digest,
    output logic                  ru_run,
    output logic [7:0]            ru_delay,
    output logic [DATA_W-1:0]     ru_init0,
    output logic [DATA_W-1:0]     ru_init1,
    output logic [DATA_W-1:0]     ru_init2,
    output logic [DATA_W-1:0]     ru_init3,
    output logic [DATA_W-1:0]     ru_init4,
    output logic [DATA_W-1:0]     ru_init5,
    output logic [DATA_W-1:0]     ru_init6,
    output logic [DATA_W-1:0]     ru_init7,
    output logic [DATA_W-1:0]     ru_w,
    output logic [DATA_W-1:0]     ru_k,
    input  logic [DATA_W-1:0]     ru_out0,
    input  logic [DATA_W-1:0]     ru_out1,
    input  logic [DATA_W-1:0]     ru_out2,
    input  logic [DATA_W-1:0]     ru_out3,
    input  logic [DATA_W-1:0]     ru_out4,
    input  logic [DATA_W-1:0]     ru_out5,
    input  logic [DATA_W-1:0]     ru_out6,
    input  logic [DATA_W-1:0]     ru_out7
);

    localparam int unsigned NWORDS  = 16;
    localparam int unsigned NHASH   = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned RND_W   = 7;
    localparam int unsigned ST_W    = 3;

    localparam logic [ST_W-1:0] S_IDLE = 3'd0;
    localparam logic [ST_W-1:0] S_LOAD = 3'd1;
    localparam logic [ST_W-1:0] S_RUN  = 3'd2;
    localparam logic [ST_W-1:0] S_CAPT = 3'd3;
    localparam logic [ST_W-1:0] S_DONE = 3'd4;

    localparam logic [DATA_W-1:0] IV [NHASH] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [DATA_W-1:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    logic [ST_W-1:0]    state;
    logic [ST_W-1:0]    state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [RND_W-1:0]   rnd;
    logic [DATA_W-1:0]  wbuf [NWORDS];
    logic [DATA_W-1:0]  h [NHASH];
    logic [DATA_W-1:0]  ru_out [NHASH];
    logic               accept;
    logic               in_round;
    logic [5:0]         t;
    logic [CNT_W-1:0]   ti;
    logic [DATA_W-1:0]  w_exp;
    logic [DATA_W-1:0]  w_cur;

    assign ru_out[0] = ru_out0;
    assign ru_out[1] = ru_out1;
    assign ru_out[2] = ru_out2;
    assign ru_out[3] = ru_out3;
    assign ru_out[4] = ru_out4;
    assign ru_out[5] = ru_out5;
    assign ru_out[6] = ru_out6;
    assign ru_out[7] = ru_out7;

    assign in_ready = ((state == S_IDLE) || (state == S_LOAD)) && !hash_init;
    assign accept   = in_valid && in_ready;
    assign digest   = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    assign ru_delay = 8'd0;
    assign ru_init0 = h[0];
    assign ru_init1 = h[1];
    assign ru_init2 = h[2];
    assign ru_init3 = h[3];
    assign ru_init4 = h[4];
    assign ru_init5 = h[5];
    assign ru_init6 = h[6];
    assign ru_init7 = h[7];

    // rnd counts RUN cycles 0..64; round t = rnd is computed now and presented next cycle
    assign in_round = (state == S_RUN) && !rnd[RND_W-1];
    assign t        = rnd[5:0];
    assign ti       = rnd[CNT_W-1:0];
    assign w_exp    = sig1(wbuf[ti - 4'd2]) + wbuf[ti - 4'd7] + sig0(wbuf[ti - 4'd15]) + wbuf[ti];
    assign w_cur    = (rnd < 7'd16) ? wbuf[ti] : w_exp;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_LOAD;
            S_LOAD:  if (accept && (cnt == 4'd15)) state_nxt = S_RUN;
            S_RUN:   if (rnd == 7'd64) state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control, hash state and registered round-unit drive
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            rnd          <= '0;
            ru_run       <= 1'b0;
            ru_w         <= '0;
            ru_k         <= '0;
            busy         <= 1'b0;
            digest_valid <= 1'b0;
            for (int i = 0; i < NHASH; i++) h[i] <= IV[i];
        end else begin
            ru_run       <= (state == S_LOAD) && accept && (cnt == 4'd15);
            busy         <= (state_nxt == S_RUN) || (state_nxt == S_CAPT);
            digest_valid <= (state == S_CAPT);
            ru_w         <= in_round ? w_cur : '0;
            ru_k         <= in_round ? K_ROM[t] : '0;
            if (accept) cnt <= cnt + 4'd1;
            if (state == S_RUN) rnd <= rnd + 7'd1;
            else                rnd <= '0;
            if ((state == S_IDLE) && hash_init) begin
                for (int i = 0; i < NHASH; i++) h[i] <= IV[i];
            end else if (state == S_CAPT) begin
                for (int i = 0; i < NHASH; i++) h[i] <= h[i] + ru_out[i];
            end
        end
    end

    // Circular message buffer: loaded by the stream, overwritten by the expansion
    always_ff @(posedge clk) begin
        if (accept) wbuf[cnt] <= in_data;
        else if (in_round && (rnd >= 7'd16)) wbuf[ti] <= w_exp;
    end

endmodule

// File: tb/tb_sha256_round_sched.sv
// Scoreboard bench for sha256_round_sched with a behavioural SHA-256 round unit.
module tb_sha256_round_sched;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV_D  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk = 1'b0;
    logic rst, hash_init, in_valid, in_ready, busy, digest_valid, ru_run;
    logic [31:0] in_data, ru_w, ru_k;
    logic [255:0] digest;
    logic [7:0] ru_delay;
    logic [31:0] ru_init0, ru_init1, ru_init2, ru_init3, ru_init4, ru_init5, ru_init6, ru_init7;
    logic [31:0] ru_out0, ru_out1, ru_out2, ru_out3, ru_out4, ru_out5, ru_out6, ru_out7;

    always #5 clk = ~clk;

    sha256_round_sched #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .hash_init(hash_init), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .digest_valid(digest_valid), .digest(digest),
        .ru_run(ru_run), .ru_delay(ru_delay),
        .ru_init0(ru_init0), .ru_init1(ru_init1), .ru_init2(ru_init2), .ru_init3(ru_init3),
        .ru_init4(ru_init4), .ru_init5(ru_init5), .ru_init6(ru_init6), .ru_init7(ru_init7),
        .ru_w(ru_w), .ru_k(ru_k),
        .ru_out0(ru_out0), .ru_out1(ru_out1), .ru_out2(ru_out2), .ru_out3(ru_out3),
        .ru_out4(ru_out4), .ru_out5(ru_out5), .ru_out6(ru_out6), .ru_out7(ru_out7)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] rstep(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        {a, b, c, d, e, f, g, hh} = s;
        t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Behavioural round unit: loads on run, then one round per cycle for 64 cycles
    logic [255:0] rs = '0;
    int rcnt = 0;
    always @(posedge clk) begin
        if (rst) rcnt <= 0;
        else if (ru_run) begin
            rs   <= {ru_init0, ru_init1, ru_init2, ru_init3, ru_init4, ru_init5, ru_init6, ru_init7};
            rcnt <= 64;
        end else if (rcnt > 0) begin
            rs   <= rstep(rs, ru_w, ru_k);
            rcnt <= rcnt - 1;
        end
    end
    assign {ru_out0, ru_out1, ru_out2, ru_out3, ru_out4, ru_out5, ru_out6, ru_out7} = rs;

    typedef struct {
        bit           chk;
        logic [255:0] dig;
        int unsigned  acyc;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc = 0;
    int n_dv = 0, n_run = 0, bp_viol = 0, sched_t = 64;
    bit sched_en = 1'b0;
    logic [31:0] wsw [64];
    logic [31:0] abc_blk [16];
    logic [31:0] nb1 [16];
    logic [31:0] nb2 [16];
    exp_t mon_e;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard pops on digest_valid, plus activity counters
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready && busy) bp_viol++;
            if (ru_run) n_run++;
            if (digest_valid) begin
                n_dv++;
                if (sb.size() == 0) check("unexpected_digest_valid", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("digest_valid_cycle", 256'(cyc), 256'(mon_e.acyc + 67));
                    if (mon_e.chk) check("digest", digest, mon_e.dig);
                end
            end
        end
    end

    // Schedule monitor: ru_w/ru_k per round against the software schedule
    always @(negedge clk) begin
        if (rst) sched_t = 64;
        else if (ru_run) sched_t = 0;
        else if (sched_t < 64) begin
            if (sched_en) begin
                check($sformatf("ru_w[%0d]", sched_t), 256'(ru_w), 256'(wsw[sched_t]));
                check($sformatf("ru_k[%0d]", sched_t), 256'(ru_k), 256'(KT[sched_t]));
                if (sched_t == 16) check("w16", 256'(ru_w), 256'h61626380);
                if (sched_t == 63) check("w63", 256'(ru_w), 256'h12b1edeb);
            end
            sched_t++;
        end
    end

    task automatic send_word(input logic [31:0] d, input bit last, input bit chk_d,
                             input logic [255:0] dig, output int unsigned acyc);
        int n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        acyc = cyc;
        if (last) begin
            e.chk = chk_d; e.dig = dig; e.acyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [31:0] blk [16], input int first, input bit chk_d,
                              input logic [255:0] dig, input bit gaps, input bit hold);
        int unsigned ac;
        for (int i = first; i < 16; i++) begin
            if (gaps) repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
            send_word(blk[i], i == 15, chk_d, dig, ac);
        end
        if (hold) begin
            in_valid = 1'b1;
            in_data  = 32'hdeadbeef;
            repeat (55) @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_init();
        hash_init = 1'b1;
        @(posedge clk); #1;
        hash_init = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ac, c0;
        int r0, d0;
        rst = 1'b1; hash_init = 1'b0; in_valid = 1'b0; in_data = '0;

        abc_blk[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) abc_blk[i] = 32'h0;
        abc_blk[15] = 32'h00000018;
        nb1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        for (int i = 0; i < 15; i++) nb2[i] = 32'h0;
        nb2[15] = 32'h000001c0;
        for (int i = 0; i < 16; i++) wsw[i] = abc_blk[i];
        for (int i = 16; i < 64; i++)
            wsw[i] = (rotr(wsw[i-2], 17) ^ rotr(wsw[i-2], 19) ^ (wsw[i-2] >> 10)) + wsw[i-7]
                   + (rotr(wsw[i-15], 7) ^ rotr(wsw[i-15], 18) ^ (wsw[i-15] >> 3)) + wsw[i-16];

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 256'(in_ready), 1);
        check("rst_busy", 256'(busy), 0);
        check("rst_digest_valid", 256'(digest_valid), 0);
        check("rst_ru_run", 256'(ru_run), 0);
        check("rst_ru_w", 256'(ru_w), 0);
        check("rst_ru_k", 256'(ru_k), 0);
        check("rst_digest", digest, IV_D);
        check("ru_delay", 256'(ru_delay), 0);
        @(posedge clk); #1;

        // Single "abc" block with per-round schedule check
        pulse_init();
        sched_en = 1'b1;
        send_block(abc_blk, 0, 1'b1, ABC_D, 1'b0, 1'b0);
        drain();
        sched_en = 1'b0;
        check("ru_init_is_h", 256'({ru_init0, ru_init1, ru_init2, ru_init3, ru_init4, ru_init5, ru_init6, ru_init7}), ABC_D);

        // Two-block NIST message, blocks streamed back-to-back
        d0 = n_dv;
        pulse_init();
        send_block(nb1, 0, 1'b0, '0, 1'b0, 1'b0);
        send_block(nb2, 0, 1'b1, TWO_D, 1'b0, 1'b0);
        drain();
        check("two_block_pulses", 256'(n_dv - d0), 2);

        // Backpressure: random gaps, in_valid held during RUN
        r0 = n_run;
        pulse_init();
        send_block(abc_blk, 0, 1'b1, ABC_D, 1'b1, 1'b1);
        drain();
        check("ru_run_cycles", 256'(n_run - r0), 1);
        check("accept_while_busy", 256'(bp_viol), 0);

        // hash_init together with in_valid in IDLE (H currently the abc digest)
        hash_init = 1'b1; in_valid = 1'b1; in_data = abc_blk[0];
        c0 = cyc;
        @(negedge clk);
        check("collide_in_ready", 256'(in_ready), 0);
        @(posedge clk); #1;
        hash_init = 1'b0;
        send_word(abc_blk[0], 1'b0, 1'b0, '0, ac);
        check("collide_accept_cycle", 256'(ac), 256'(c0 + 1));
        check("collide_h_iv", digest, IV_D);
        send_block(abc_blk, 1, 1'b1, ABC_D, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        pulse_init();
        drain();

        // Reset at RUN round 30, then a fresh block from IV
        send_block(abc_blk, 0, 1'b1, ABC_D, 1'b0, 1'b0);
        repeat (31) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrun_rst_busy", 256'(busy), 0);
        check("midrun_rst_ru_run", 256'(ru_run), 0);
        check("midrun_rst_in_ready", 256'(in_ready), 1);
        check("midrun_rst_ru_w", 256'(ru_w), 0);
        check("midrun_rst_digest", digest, IV_D);
        @(posedge clk); #1;
        d0 = n_dv;
        send_block(abc_blk, 0, 1'b1, ABC_D, 1'b0, 1'b0);
        drain();
        check("post_rst_pulses", 256'(n_dv - d0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
